// File: rtl/seq_stage_ctrl_if.sv
// Handshake/status bundle between the sequencer and the datapath stages of seq_stage_ctrl.
interface seq_stage_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             hlt;
  logic             instr_validity;
  logic             imem_error;
  logic             dmem_error;
  logic             mem_ready;
  logic             step;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_en;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, hlt, instr_validity, imem_error, dmem_error, mem_ready, step,
    input  fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, stat, busy,
    input  cycle_count, instr_count
  );

  modport slave (
    input  start, hlt, instr_validity, imem_error, dmem_error, mem_ready, step,
    output fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, stat, busy,
    output cycle_count, instr_count
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle processor sequencer: one-hot stage enables, status code and saturating counters.
// Optional single-step pause after each instruction when SEQ_SINGLE_STEP_EN is defined.
module seq_stage_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  seq_stage_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcUpd, StPause, StHalted
  } state_e;

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatHlt = 3'd2;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [2:0] StatIns = 3'd4;
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [5:0]       en_q, en_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      StIdle:      if (bus.start) state_d = StFetch;
      StFetch:     state_d = StDecode;
      StDecode: begin
        // Fetch status arrives one cycle after fetch_en; faults outrank a clean halt.
        if (bus.imem_error) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end else if (!bus.instr_validity) begin
          state_d = StHalted;
          stat_d  = StatIns;
        end else if (bus.hlt) begin
          state_d = StHalted;
          stat_d  = StatHlt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute:   state_d = StMemory;
      StMemory: begin
        if (bus.dmem_error) begin
          state_d = StHalted;
          stat_d  = StatAdr;
        end else if (bus.mem_ready) begin
          state_d = StWriteback;
        end
      end
      StWriteback: state_d = StPcUpd;
`ifdef SEQ_SINGLE_STEP_EN
      StPcUpd:     state_d = StPause;
      StPause:     if (bus.step) state_d = StFetch;
`else
      StPcUpd:     state_d = StFetch;
      StPause:     state_d = StFetch;
`endif
      StHalted:    state_d = StHalted;
      default:     state_d = StIdle;
    endcase
  end

`ifndef SEQ_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = bus.step;
`endif

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    en_d = '0;
    unique case (state_d)
      StFetch:     en_d = 6'b100000;
      StDecode:    en_d = 6'b010000;
      StExecute:   en_d = 6'b001000;
      StMemory:    en_d = 6'b000100;
      StWriteback: en_d = 6'b000010;
      StPcUpd:     en_d = 6'b000001;
      default:     en_d = '0;
    endcase
    busy_d  = (state_d != StIdle) && (state_d != StHalted);
    cyc_d   = (busy_q && (cyc_q != CntMax)) ? cyc_q + CNT_W'(1) : cyc_q;
    instr_d = ((state_q == StPcUpd) && (instr_q != CntMax)) ? instr_q + CNT_W'(1) : instr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stat_q  <= StatAok;
      en_q    <= '0;
      busy_q  <= 1'b0;
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.fetch_en    = en_q[5];
  assign bus.decode_en   = en_q[4];
  assign bus.exec_en     = en_q[3];
  assign bus.mem_en      = en_q[2];
  assign bus.wb_en       = en_q[1];
  assign bus.pc_en       = en_q[0];
  assign bus.stat        = stat_q;
  assign bus.busy        = busy_q;
  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Table-driven bench for seq_stage_ctrl: per-cycle vectors, scoreboard queue, counter model.
module tb_seq_stage_ctrl;

  typedef struct {
    logic       rst, start, hlt, vld, ie, de, mr, st;
    logic [5:0] en;
    logic [2:0] stat;
    logic       busy;
  } vec_t;

  localparam logic [5:0] EF = 6'b100000;
  localparam logic [5:0] ED = 6'b010000;
  localparam logic [5:0] EE = 6'b001000;
  localparam logic [5:0] EM = 6'b000100;
  localparam logic [5:0] EW = 6'b000010;
  localparam logic [5:0] EP = 6'b000001;
  localparam logic [5:0] EN = 6'b000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_stage_ctrl_if #(.CNT_W(32)) if0 ();
  seq_stage_ctrl_if #(.CNT_W(4))  if4 ();

  assign if4.start          = if0.start;
  assign if4.hlt            = if0.hlt;
  assign if4.instr_validity = if0.instr_validity;
  assign if4.imem_error     = if0.imem_error;
  assign if4.dmem_error     = if0.dmem_error;
  assign if4.mem_ready      = if0.mem_ready;
  assign if4.step           = if0.step;

  seq_stage_ctrl #(.CNT_W(32)) u_dut (.clk(clk), .rst(rst), .bus(if0));
  seq_stage_ctrl #(.CNT_W(4))  u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int unsigned exp_cyc = 0, exp_instr = 0;
  logic [3:0]  exp_cyc4 = '0, exp_instr4 = '0;
  logic        prev_busy = 1'b0, prev_pc = 1'b0;

  task automatic add(input logic r, s, h, vld, ie, de, mr, st,
                     input logic [5:0] en, input logic [2:0] sta, input logic b);
    vec_t v;
    v.rst = r; v.start = s; v.hlt = h; v.vld = vld; v.ie = ie; v.de = de; v.mr = mr; v.st = st;
    v.en = en; v.stat = sta; v.busy = b;
    tbl.push_back(v);
  endtask

  // Vectors for one clean instruction, starting with the FSM in FETCH.
  task automatic ins_ok(input int waits, input logic st);
    add(0, 0, 0, 1, 0, 0, 1, st, ED, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, st, EE, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, st, EM, 3'd1, 1);
    for (int k = 0; k < waits; k++) add(0, 0, 0, 1, 0, 0, 0, st, EM, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, st, EW, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, st, EP, 3'd1, 1);
`ifdef SEQ_SINGLE_STEP_EN
    add(0, 0, 0, 1, 0, 0, 1, 1'b1, EN, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 1'b0, EN, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 1'b1, EF, 3'd1, 1);
`else
    add(0, 0, 0, 1, 0, 0, 1, st, EF, 3'd1, 1);
`endif
  endtask

  task automatic ins_fault(input logic h, vld, ie, input logic [2:0] code);
    add(0, 0, 0, 1, 0, 0, 1, 0, ED, 3'd1, 1);
    add(0, 0, h, vld, ie, 0, 1, 0, EN, code, 0);
  endtask

  task automatic check(input int idx, input vec_t e);
    logic [5:0] act_en;
    act_en = {if0.fetch_en, if0.decode_en, if0.exec_en, if0.mem_en, if0.wb_en, if0.pc_en};
    if (e.rst) begin
      exp_cyc = 0; exp_instr = 0; exp_cyc4 = '0; exp_instr4 = '0;
    end else begin
      if (prev_busy) begin
        exp_cyc++;
        if (exp_cyc4 != 4'hf) exp_cyc4 = exp_cyc4 + 4'd1;
      end
      if (prev_pc) begin
        exp_instr++;
        if (exp_instr4 != 4'hf) exp_instr4 = exp_instr4 + 4'd1;
      end
    end
    prev_busy = e.busy;
    prev_pc   = (e.en == EP);

    n_tests++;
    if ({act_en, if0.stat, if0.busy} !== {e.en, e.stat, e.busy}) begin
      n_fail++;
      $display("FAIL vec%0d outputs: got en=%b stat=%0d busy=%b, want en=%b stat=%0d busy=%b",
               idx, act_en, if0.stat, if0.busy, e.en, e.stat, e.busy);
    end
    n_tests++;
    if (if0.cycle_count !== exp_cyc || if0.instr_count !== exp_instr) begin
      n_fail++;
      $display("FAIL vec%0d counters: got cyc=%0d instr=%0d, want cyc=%0d instr=%0d",
               idx, if0.cycle_count, if0.instr_count, exp_cyc, exp_instr);
    end
    n_tests++;
    if (if4.cycle_count !== exp_cyc4 || if4.instr_count !== exp_instr4) begin
      n_fail++;
      $display("FAIL vec%0d sat4 counters: got cyc=%0d instr=%0d, want cyc=%0d instr=%0d",
               idx, if4.cycle_count, if4.instr_count, exp_cyc4, exp_instr4);
    end
  endtask

  initial begin
    rst = 1'b1;
    if0.start = 0; if0.hlt = 0; if0.instr_validity = 1; if0.imem_error = 0;
    if0.dmem_error = 0; if0.mem_ready = 1; if0.step = 0;

    // Reset, idle, then three clean instructions with step toggling.
    add(1, 0, 0, 1, 0, 0, 1, 0, EN, 3'd1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    ins_ok(0, 0);
    ins_ok(0, 1);
    ins_ok(0, 0);
    // Clean halt, then start and step ignored in HALTED.
    ins_fault(1, 1, 0, 3'd2);
    add(0, 1, 0, 1, 0, 0, 1, 0, EN, 3'd2, 0);
    add(0, 0, 0, 1, 0, 0, 1, 1, EN, 3'd2, 0);
    // imem_error outranks invalid instruction and hlt.
    add(1, 0, 0, 1, 0, 0, 1, 0, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    ins_fault(1, 0, 1, 3'd3);
    // Invalid instruction alone.
    add(1, 0, 0, 1, 0, 0, 1, 0, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    ins_fault(0, 0, 0, 3'd4);
    // Four-cycle memory stall, then a data fault on the third MEMORY cycle.
    add(1, 0, 0, 1, 0, 0, 1, 0, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    ins_ok(4, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, ED, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, EE, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, EM, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, EM, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, EM, 3'd1, 1);
    add(0, 0, 0, 1, 0, 1, 1, 0, EN, 3'd3, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, EN, 3'd3, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EN, 3'd3, 0);
    // Reset during a MEMORY wait dominates start/step, then restart.
    add(1, 0, 0, 1, 0, 0, 1, 0, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, ED, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, EE, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, EM, 3'd1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, EM, 3'd1, 1);
    add(1, 1, 0, 1, 0, 0, 0, 1, EN, 3'd1, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, EF, 3'd1, 1);
    // Long run drives the 4-bit counters into saturation.
    for (int n = 0; n < 17; n++) ins_ok(0, n[0]);

    for (int i = 0; i < tbl.size(); i++) begin
      rst                = tbl[i].rst;
      if0.start          = tbl[i].start;
      if0.hlt            = tbl[i].hlt;
      if0.instr_validity = tbl[i].vld;
      if0.imem_error     = tbl[i].ie;
      if0.dmem_error     = tbl[i].de;
      if0.mem_ready      = tbl[i].mr;
      if0.step           = tbl[i].st;
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      check(i, sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
